// File: rtl/i2c_byte_ctl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | i2c_byte_ctl : byte-level I2C sequencer driving i2c_bit_ctl commands.    |
// | Option macro: I2C_BYTE_NACK_AUTOSTOP_EN (NACK after write forces STOP).  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module i2c_byte_ctl #(
  parameter int CMD_W = 3
) (
  input  logic             sysclk_i,
  input  logic             reset_n_i,
  input  logic             enable_i,
  input  logic             go_i,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic             write_i,
  input  logic             read_i,
  input  logic             ack_i,
  input  logic [7:0]       din_i,
  output logic [7:0]       dout_o,
  output logic             done_o,
  output logic             busy_o,
  output logic             rxack_o,
  output logic             arblost_o,
  output logic [CMD_W-1:0] bit_cmd_o,
  input  logic             bit_cmd_ack_i,
  output logic             bit_txd_o,
  input  logic             bit_rxd_i,
  input  logic             arblost_i
);

  localparam logic [CMD_W-1:0] CMD_IDLE   = CMD_W'(0);
  localparam logic [CMD_W-1:0] CMD_START  = CMD_W'(1);
  localparam logic [CMD_W-1:0] CMD_STOP   = CMD_W'(2);
  localparam logic [CMD_W-1:0] CMD_WRITE  = CMD_W'(3);
  localparam logic [CMD_W-1:0] CMD_READ   = CMD_W'(4);
  localparam logic [CMD_W-1:0] CMD_WR_ACK = CMD_W'(5);
  localparam logic [CMD_W-1:0] CMD_RD_ACK = CMD_W'(6);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_WRITE = 3'd2;
  localparam logic [2:0] ST_READ  = 3'd3;
  localparam logic [2:0] ST_ACK   = 3'd4;
  localparam logic [2:0] ST_STOP  = 3'd5;

  logic [2:0]       state, state_nxt;
  logic [CMD_W-1:0] cmd, cmd_nxt;
  logic             txd, txd_nxt;
  logic [7:0]       sr, sr_nxt;
  logic [2:0]       cnt, cnt_nxt;
  logic [7:0]       dout, dout_nxt;
  logic             done, done_nxt;
  logic             busy, busy_nxt;
  logic             rxack, rxack_nxt;
  logic             arblost, arblost_nxt;
  logic             req_start, req_start_nxt;
  logic             req_stop, req_stop_nxt;
  logic             req_write, req_write_nxt;
  logic             req_read, req_read_nxt;
  logic             req_ack, req_ack_nxt;

  logic       any_flag;
  logic       accept;
  logic       arb;
  logic       step;
  logic       ack_stop;
  logic [2:0] after_start;

  assign any_flag = start_i | stop_i | write_i | read_i;
  assign accept   = enable_i && (state == ST_IDLE) && go_i && any_flag;
  // arbitration loss outranks a simultaneous bit acknowledge
  assign arb      = enable_i && (state != ST_IDLE) && arblost_i;
  assign step     = enable_i && (state != ST_IDLE) && !arblost_i && bit_cmd_ack_i;

`ifdef I2C_BYTE_NACK_AUTOSTOP_EN
  assign ack_stop = req_stop | (req_write & bit_rxd_i);
`else
  assign ack_stop = req_stop;
`endif

  always_comb begin
    if (req_write)     after_start = ST_WRITE;
    else if (req_read) after_start = ST_READ;
    else if (req_stop) after_start = ST_STOP;
    else               after_start = ST_IDLE;
  end

  always_ff @(posedge sysclk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state     <= ST_IDLE;
      cmd       <= CMD_IDLE;
      txd       <= 1'b1;
      sr        <= 8'h00;
      cnt       <= 3'd0;
      dout      <= 8'h00;
      done      <= 1'b0;
      busy      <= 1'b0;
      rxack     <= 1'b0;
      arblost   <= 1'b0;
      req_start <= 1'b0;
      req_stop  <= 1'b0;
      req_write <= 1'b0;
      req_read  <= 1'b0;
      req_ack   <= 1'b0;
    end else begin
      state     <= state_nxt;
      cmd       <= cmd_nxt;
      txd       <= txd_nxt;
      sr        <= sr_nxt;
      cnt       <= cnt_nxt;
      dout      <= dout_nxt;
      done      <= done_nxt;
      busy      <= busy_nxt;
      rxack     <= rxack_nxt;
      arblost   <= arblost_nxt;
      req_start <= req_start_nxt;
      req_stop  <= req_stop_nxt;
      req_write <= req_write_nxt;
      req_read  <= req_read_nxt;
      req_ack   <= req_ack_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (!enable_i || arb) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (start_i)      state_nxt = ST_START;
            else if (write_i) state_nxt = ST_WRITE;
            else if (read_i)  state_nxt = ST_READ;
            else              state_nxt = ST_STOP;
          end
        end
        ST_START: if (bit_cmd_ack_i) state_nxt = after_start;
        ST_WRITE,
        ST_READ:  if (bit_cmd_ack_i && cnt == 3'd0) state_nxt = ST_ACK;
        ST_ACK:   if (bit_cmd_ack_i) state_nxt = ack_stop ? ST_STOP : ST_IDLE;
        ST_STOP:  if (bit_cmd_ack_i) state_nxt = ST_IDLE;
        default:  state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    cmd_nxt       = cmd;
    txd_nxt       = txd;
    sr_nxt        = sr;
    cnt_nxt       = cnt;
    dout_nxt      = dout;
    done_nxt      = 1'b0;
    busy_nxt      = busy;
    rxack_nxt     = rxack;
    arblost_nxt   = arblost;
    req_start_nxt = req_start;
    req_stop_nxt  = req_stop;
    req_write_nxt = req_write;
    req_read_nxt  = req_read;
    req_ack_nxt   = req_ack;
    if (!enable_i) begin
      cmd_nxt     = CMD_IDLE;
      txd_nxt     = 1'b1;
      cnt_nxt     = 3'd0;
      busy_nxt    = 1'b0;
      arblost_nxt = 1'b0;
    end else if (arb) begin
      cmd_nxt     = CMD_IDLE;
      txd_nxt     = 1'b1;
      cnt_nxt     = 3'd0;
      busy_nxt    = 1'b0;
      arblost_nxt = 1'b1;
      done_nxt    = 1'b1;
    end else begin
      if (accept) begin
        req_start_nxt = start_i;
        req_stop_nxt  = stop_i;
        req_write_nxt = write_i;
        req_read_nxt  = read_i & ~write_i;
        req_ack_nxt   = ack_i;
        sr_nxt        = din_i;
        busy_nxt      = 1'b1;
        arblost_nxt   = 1'b0;
      end
      if (step) begin
        case (state)
          ST_WRITE: sr_nxt = {sr[6:0], 1'b0};
          ST_READ:  sr_nxt = {sr[6:0], bit_rxd_i};
          ST_ACK: begin
            if (req_write) rxack_nxt = bit_rxd_i;
            else           dout_nxt  = sr;
          end
          default: ;
        endcase
        if ((state == ST_WRITE || state == ST_READ) && cnt != 3'd0)
          cnt_nxt = cnt - 3'd1;
        if (state_nxt == ST_IDLE) begin
          done_nxt = 1'b1;
          busy_nxt = 1'b0;
        end
      end
      // the command register always reflects the phase being entered
      if (accept || step) begin
        if ((state_nxt == ST_WRITE || state_nxt == ST_READ) && state_nxt != state)
          cnt_nxt = 3'd7;
        case (state_nxt)
          ST_START: begin cmd_nxt = CMD_START; txd_nxt = 1'b1;      end
          ST_WRITE: begin cmd_nxt = CMD_WRITE; txd_nxt = sr_nxt[7]; end
          ST_READ:  begin cmd_nxt = CMD_READ;  txd_nxt = 1'b1;      end
          ST_ACK: begin
            if (req_write_nxt) begin cmd_nxt = CMD_RD_ACK; txd_nxt = 1'b1;        end
            else               begin cmd_nxt = CMD_WR_ACK; txd_nxt = req_ack_nxt; end
          end
          ST_STOP:  begin cmd_nxt = CMD_STOP;  txd_nxt = 1'b1;      end
          default:  begin cmd_nxt = CMD_IDLE;  txd_nxt = 1'b1;      end
        endcase
      end
    end
  end

  assign bit_cmd_o = cmd;
  assign bit_txd_o = txd;
  assign dout_o    = dout;
  assign done_o    = done;
  assign busy_o    = busy;
  assign rxack_o   = rxack;
  assign arblost_o = arblost;

endmodule
`default_nettype wire

// File: tb/tb_i2c_byte_ctl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_i2c_byte_ctl : directed self-checking bench for i2c_byte_ctl.         |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_i2c_byte_ctl;

  localparam logic [2:0] C_IDLE   = 3'd0;
  localparam logic [2:0] C_START  = 3'd1;
  localparam logic [2:0] C_STOP   = 3'd2;
  localparam logic [2:0] C_WRITE  = 3'd3;
  localparam logic [2:0] C_READ   = 3'd4;
  localparam logic [2:0] C_WR_ACK = 3'd5;
  localparam logic [2:0] C_RD_ACK = 3'd6;

  logic       sysclk_i = 1'b0;
  logic       reset_n_i, enable_i, go_i, start_i, stop_i, write_i, read_i, ack_i;
  logic [7:0] din_i;
  logic [7:0] dout_o;
  logic       done_o, busy_o, rxack_o, arblost_o;
  logic [2:0] bit_cmd_o;
  logic       bit_cmd_ack_i, bit_txd_o, bit_rxd_i, arblost_i;

  int checks = 0;
  int errors = 0;

  logic [2:0] log_cmd [0:31];
  logic       log_txd [0:31];
  int         log_n;
  int         done_cnt;

  always #5 sysclk_i = ~sysclk_i;

  i2c_byte_ctl #(.CMD_W(3)) dut (
    .sysclk_i(sysclk_i), .reset_n_i(reset_n_i), .enable_i(enable_i),
    .go_i(go_i), .start_i(start_i), .stop_i(stop_i), .write_i(write_i),
    .read_i(read_i), .ack_i(ack_i), .din_i(din_i), .dout_o(dout_o),
    .done_o(done_o), .busy_o(busy_o), .rxack_o(rxack_o), .arblost_o(arblost_o),
    .bit_cmd_o(bit_cmd_o), .bit_cmd_ack_i(bit_cmd_ack_i), .bit_txd_o(bit_txd_o),
    .bit_rxd_i(bit_rxd_i), .arblost_i(arblost_i)
  );

  task automatic do_go(input logic s, input logic p, input logic w, input logic r,
                       input logic a, input logic [7:0] d);
    go_i = 1'b1; start_i = s; stop_i = p; write_i = w; read_i = r; ack_i = a; din_i = d;
    @(posedge sysclk_i); #1;
    go_i = 1'b0; start_i = 1'b0; stop_i = 1'b0; write_i = 1'b0; read_i = 1'b0;
  endtask

  // bit-level responder: acks each command one cycle after it appears
  task automatic serve(input logic [7:0] rxbyte, input logic ackbit, input int arb_at);
    logic [7:0] rx_sh;
    int         since_done;
    bit         ack_prev;
    rx_sh = rxbyte; log_n = 0; done_cnt = 0; since_done = -1; ack_prev = 0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      if (done_o === 1'b1) begin
        done_cnt++;
        if (since_done < 0) since_done = 0;
        checks++;
        if (!ack_prev || bit_cmd_o !== C_IDLE || busy_o !== 1'b0) begin
          errors++;
          $display("FAIL done_timing: ack_prev=%0d cmd=%0d busy=%b, required ack_prev=1 cmd=0 busy=0",
                   ack_prev, bit_cmd_o, busy_o);
        end
      end
      if (ack_prev) begin
        bit_cmd_ack_i = 1'b0; arblost_i = 1'b0; ack_prev = 0;
      end else if (bit_cmd_o !== C_IDLE && log_n < 32) begin
        log_cmd[log_n] = bit_cmd_o;
        log_txd[log_n] = bit_txd_o;
        bit_rxd_i = 1'b1;
        if (bit_cmd_o == C_READ) begin
          bit_rxd_i = rx_sh[7];
          rx_sh = {rx_sh[6:0], 1'b0};
        end else if (bit_cmd_o == C_RD_ACK) begin
          bit_rxd_i = ackbit;
        end
        if (log_n == arb_at) arblost_i = 1'b1;
        bit_cmd_ack_i = 1'b1; ack_prev = 1; log_n++;
      end
      if (since_done >= 0) begin
        if (since_done == 3) break;
        since_done++;
      end
      @(posedge sysclk_i); #1;
    end
    if (since_done < 0) begin
      checks++; errors++;
      $display("FAIL serve_timeout: no done_o within 300 cycles, got %0d commands", log_n);
    end
  endtask

  task automatic test_reset;
    checks++; if (bit_cmd_o !== C_IDLE) begin errors++; $display("FAIL rst_cmd: got %0d want 0", bit_cmd_o); end
    checks++; if (bit_txd_o !== 1'b1)   begin errors++; $display("FAIL rst_txd: got %b want 1", bit_txd_o); end
    checks++; if (dout_o !== 8'h00)     begin errors++; $display("FAIL rst_dout: got %h want 00", dout_o); end
    checks++; if (done_o !== 1'b0)      begin errors++; $display("FAIL rst_done: got %b want 0", done_o); end
    checks++; if (busy_o !== 1'b0)      begin errors++; $display("FAIL rst_busy: got %b want 0", busy_o); end
    checks++; if (rxack_o !== 1'b0)     begin errors++; $display("FAIL rst_rxack: got %b want 0", rxack_o); end
    checks++; if (arblost_o !== 1'b0)   begin errors++; $display("FAIL rst_arblost: got %b want 0", arblost_o); end
  endtask

  task automatic test_write;
    logic [7:0] pat;
    logic [2:0] e;
    pat = 8'hA5;
    do_go(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'hA5);
    checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL wr_busy: got %b want 1", busy_o); end
    serve(8'h00, 1'b0, -1);
    checks++; if (log_n != 10) begin errors++; $display("FAIL wr_ncmd: got %0d want 10", log_n); end
    for (int i = 0; i < 10; i++) begin
      e = (i == 0) ? C_START : (i == 9) ? C_RD_ACK : C_WRITE;
      checks++;
      if (log_cmd[i] !== e) begin errors++; $display("FAIL wr_cmd[%0d]: got %0d want %0d", i, log_cmd[i], e); end
    end
    for (int i = 1; i <= 8; i++) begin
      checks++;
      if (log_txd[i] !== pat[8-i]) begin errors++; $display("FAIL wr_txd[%0d]: got %b want %b", i, log_txd[i], pat[8-i]); end
    end
    checks++; if (rxack_o !== 1'b0) begin errors++; $display("FAIL wr_rxack: got %b want 0", rxack_o); end
    checks++; if (done_cnt != 1)    begin errors++; $display("FAIL wr_done_cnt: got %0d want 1", done_cnt); end
  endtask

  task automatic test_read;
    logic [2:0] e;
    do_go(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h00);
    serve(8'h3C, 1'b0, -1);
    checks++; if (log_n != 10) begin errors++; $display("FAIL rd_ncmd: got %0d want 10", log_n); end
    for (int i = 0; i < 10; i++) begin
      e = (i == 8) ? C_WR_ACK : (i == 9) ? C_STOP : C_READ;
      checks++;
      if (log_cmd[i] !== e) begin errors++; $display("FAIL rd_cmd[%0d]: got %0d want %0d", i, log_cmd[i], e); end
    end
    checks++; if (log_txd[8] !== 1'b1) begin errors++; $display("FAIL rd_acktxd: got %b want 1", log_txd[8]); end
    checks++; if (dout_o !== 8'h3C)    begin errors++; $display("FAIL rd_dout: got %h want 3c", dout_o); end
    checks++; if (done_cnt != 1)       begin errors++; $display("FAIL rd_done_cnt: got %0d want 1", done_cnt); end
  endtask

  // write+read together behaves as write only; NACK received
  task automatic test_nack;
    logic [7:0] pat;
    int         n_exp;
    logic [2:0] e;
    pat = 8'h5A;
`ifdef I2C_BYTE_NACK_AUTOSTOP_EN
    n_exp = 10;
`else
    n_exp = 9;
`endif
    do_go(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h5A);
    serve(8'hFF, 1'b1, -1);
    checks++; if (log_n != n_exp) begin errors++; $display("FAIL nack_ncmd: got %0d want %0d", log_n, n_exp); end
    for (int i = 0; i < n_exp; i++) begin
      e = (i < 8) ? C_WRITE : (i == 8) ? C_RD_ACK : C_STOP;
      checks++;
      if (log_cmd[i] !== e) begin errors++; $display("FAIL nack_cmd[%0d]: got %0d want %0d", i, log_cmd[i], e); end
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (log_txd[i] !== pat[7-i]) begin errors++; $display("FAIL nack_txd[%0d]: got %b want %b", i, log_txd[i], pat[7-i]); end
    end
    checks++; if (rxack_o !== 1'b1) begin errors++; $display("FAIL nack_rxack: got %b want 1", rxack_o); end
  endtask

  task automatic test_enable;
    do_go(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'hFF);
    enable_i = 1'b0;
    @(posedge sysclk_i); #1;
    checks++; if (bit_cmd_o !== C_IDLE) begin errors++; $display("FAIL en_cmd: got %0d want 0", bit_cmd_o); end
    checks++; if (busy_o !== 1'b0)      begin errors++; $display("FAIL en_busy: got %b want 0", busy_o); end
    checks++; if (done_o !== 1'b0)      begin errors++; $display("FAIL en_done: got %b want 0", done_o); end
    checks++; if (rxack_o !== 1'b1)     begin errors++; $display("FAIL en_rxack_hold: got %b want 1", rxack_o); end
    checks++; if (dout_o !== 8'h3C)     begin errors++; $display("FAIL en_dout_hold: got %h want 3c", dout_o); end
    enable_i = 1'b1;
    @(posedge sysclk_i); #1;
    checks++; if (done_o !== 1'b0)      begin errors++; $display("FAIL en_done_late: got %b want 0", done_o); end
  endtask

  task automatic test_ignored;
    do_go(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    bit_cmd_ack_i = 1'b1;
    @(posedge sysclk_i); #1;
    bit_cmd_ack_i = 1'b0;
    checks++; if (busy_o !== 1'b0)      begin errors++; $display("FAIL ign_busy: got %b want 0", busy_o); end
    checks++; if (bit_cmd_o !== C_IDLE) begin errors++; $display("FAIL ign_cmd: got %0d want 0", bit_cmd_o); end
    checks++; if (done_o !== 1'b0)      begin errors++; $display("FAIL ign_done: got %b want 0", done_o); end
  endtask

  task automatic test_arblost;
    logic [2:0] e;
    do_go(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'hC3);
    serve(8'h00, 1'b0, 4);
    checks++; if (log_n != 5) begin errors++; $display("FAIL arb_ncmd: got %0d want 5", log_n); end
    for (int i = 0; i < 5; i++) begin
      e = (i == 0) ? C_START : C_WRITE;
      checks++;
      if (log_cmd[i] !== e) begin errors++; $display("FAIL arb_cmd[%0d]: got %0d want %0d", i, log_cmd[i], e); end
    end
    checks++; if (done_cnt != 1)        begin errors++; $display("FAIL arb_done_cnt: got %0d want 1", done_cnt); end
    checks++; if (arblost_o !== 1'b1)   begin errors++; $display("FAIL arb_flag: got %b want 1", arblost_o); end
    checks++; if (busy_o !== 1'b0)      begin errors++; $display("FAIL arb_busy: got %b want 0", busy_o); end
    checks++; if (rxack_o !== 1'b1)     begin errors++; $display("FAIL arb_rxack_hold: got %b want 1", rxack_o); end
    do_go(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    checks++; if (arblost_o !== 1'b0)   begin errors++; $display("FAIL arb_clear: got %b want 0", arblost_o); end
    checks++; if (bit_cmd_o !== C_STOP) begin errors++; $display("FAIL arb_stop_cmd: got %0d want 2", bit_cmd_o); end
    serve(8'h00, 1'b0, -1);
    checks++; if (log_n != 1 || done_cnt != 1) begin
      errors++; $display("FAIL arb_stop_only: got n=%0d done=%0d want n=1 done=1", log_n, done_cnt);
    end
  endtask

  task automatic test_busy_reset;
    do_go(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    for (int k = 0; k < 3; k++) begin
      bit_cmd_ack_i = 1'b1; bit_rxd_i = 1'b1;
      @(posedge sysclk_i); #1;
      bit_cmd_ack_i = 1'b0;
      @(posedge sysclk_i); #1;
    end
    do_go(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'hFF);
    checks++; if (bit_cmd_o !== C_READ) begin errors++; $display("FAIL busy_cmd: got %0d want 4", bit_cmd_o); end
    checks++; if (busy_o !== 1'b1)      begin errors++; $display("FAIL busy_busy: got %b want 1", busy_o); end
    checks++; if (done_o !== 1'b0)      begin errors++; $display("FAIL busy_done: got %b want 0", done_o); end
    #2 reset_n_i = 1'b0;
    #1;
    checks++; if (bit_cmd_o !== C_IDLE) begin errors++; $display("FAIL arst_cmd: got %0d want 0", bit_cmd_o); end
    checks++; if (bit_txd_o !== 1'b1)   begin errors++; $display("FAIL arst_txd: got %b want 1", bit_txd_o); end
    checks++; if (dout_o !== 8'h00)     begin errors++; $display("FAIL arst_dout: got %h want 00", dout_o); end
    checks++; if (busy_o !== 1'b0)      begin errors++; $display("FAIL arst_busy: got %b want 0", busy_o); end
    checks++; if (rxack_o !== 1'b0)     begin errors++; $display("FAIL arst_rxack: got %b want 0", rxack_o); end
    checks++; if (done_o !== 1'b0)      begin errors++; $display("FAIL arst_done: got %b want 0", done_o); end
    #3 reset_n_i = 1'b1;
    @(posedge sysclk_i); #1;
  endtask

  initial begin
    reset_n_i = 1'b0; enable_i = 1'b1; go_i = 1'b0; start_i = 1'b0; stop_i = 1'b0;
    write_i = 1'b0; read_i = 1'b0; ack_i = 1'b0; din_i = 8'h00;
    bit_cmd_ack_i = 1'b0; bit_rxd_i = 1'b1; arblost_i = 1'b0;
    #22 reset_n_i = 1'b1;
    @(posedge sysclk_i); #1;
    test_reset;
    test_write;
    test_read;
    test_nack;
    test_enable;
    test_ignored;
    test_arblost;
    test_busy_reset;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/i2c_byte_ctl.md
I2C_BYTE_CTL -- requirements
Module: i2c_byte_ctl

Interface
REQ-001 SHALL have parameter: CMD_W, 3, width of bit-command bus to i2c_bit_ctl.
REQ-002 SHALL have ports:
- sysclk_i  in  1  clock.
- reset_n_i  in  1  reset, asynchronous, active-low.
- enable_i  in  1  core enable.
- go_i  in  1  one-cycle transfer request.
- start_i, stop_i, write_i, read_i  in  1 each  request flags, sampled with go_i.
- ack_i  in  1  ACK value sent after a read (0=ACK).
- din_i  in  8  byte to write.
- dout_o  out  8  byte read.
- done_o  out  1  one-cycle completion pulse.
- busy_o  out  1  transfer in progress.
- rxack_o  out  1  ACK bit received after a write.
- arblost_o  out  1  arbitration lost, sticky.
- bit_cmd_o  out  CMD_W  command to i2c_bit_ctl (CMD_* codes of i2c-def.v).
- bit_cmd_ack_i  in  1  bit command complete.
- bit_txd_o  out  1  bit value to i2c_bit_ctl.
- bit_rxd_i  in  1  sampled SDA from i2c_bit_ctl.
- arblost_i  in  1  arbitration lost from i2c_bit_ctl.

Function
REQ-003 SHALL use FSM states IDLE, START, WRITE, READ, ACK, STOP.
REQ-004 In IDLE, go_i with any flag set SHALL latch flags, din_i and ack_i, set busy_o next cycle, and go to the first requested phase in order START, WRITE/READ, STOP.
REQ-005 go_i while busy_o=1, or with no flag set, SHALL be ignored (no state change, no done_o).
REQ-006 write_i and read_i both set SHALL be treated as write only.
REQ-007 START SHALL drive CMD_START until bit_cmd_ack_i, then go to WRITE, READ, STOP or finish.
REQ-008 WRITE SHALL issue 8 CMD_WRITE, MSB first, bit_txd_o = current shift-register MSB, shifting on each bit_cmd_ack_i; 3-bit counter 7..0.
REQ-009 READ SHALL issue 8 CMD_READ, shifting bit_rxd_i into LSB on each bit_cmd_ack_i.
REQ-010 ACK after WRITE SHALL issue CMD_RD_ACK and capture bit_rxd_i into rxack_o on bit_cmd_ack_i.
REQ-011 ACK after READ SHALL issue CMD_WR_ACK with bit_txd_o=latched ack_i, and load dout_o on bit_cmd_ack_i.
REQ-012 STOP SHALL issue CMD_STOP until bit_cmd_ack_i.
REQ-013 bit_cmd_o SHALL hold stable until the cycle bit_cmd_ack_i=1, and on that edge change to the next command or CMD_IDLE, so no command repeats.
REQ-014 Finishing SHALL pulse done_o for exactly one cycle, clear busy_o and set bit_cmd_o=CMD_IDLE on the same edge; latency = last bit_cmd_ack_i + 1 cycle.
REQ-015 arblost_i=1 in any non-IDLE state SHALL abort to IDLE next edge: bit_cmd_o=CMD_IDLE, busy_o=0, arblost_o=1, done_o pulsed once.
REQ-016 arblost_o SHALL clear on the next accepted go_i.
REQ-017 arblost_i and bit_cmd_ack_i in the same cycle SHALL be resolved as arbitration loss, with no data or rxack update.
REQ-018 bit_cmd_ack_i in IDLE SHALL be ignored.

Reset
REQ-019 reset_n_i low SHALL asynchronously set: state IDLE, bit_cmd_o=CMD_IDLE, bit_txd_o=1, dout_o=0, done_o=0, busy_o=0, rxack_o=0, arblost_o=0, bit counter 0.
REQ-020 enable_i low SHALL synchronously force the same values, except dout_o and rxack_o hold; mid-transfer abort gives no done_o.

Configuration
REQ-021 With I2C_BYTE_NACK_AUTOSTOP_EN defined, rxack_o=1 after a WRITE SHALL force the STOP phase even when stop_i was not requested.
REQ-022 Without I2C_BYTE_NACK_AUTOSTOP_EN, STOP SHALL occur only when stop_i was latched.

Verification
REQ-023 go_i+start_i+write_i, din_i=8'hA5, bit model ACKs with bit_rxd_i=0 -> commands START, WRITE×8, RD_ACK; bit_txd_o 1,0,1,0,0,1,0,1; rxack_o=0; one done_o.
REQ-024 go_i+read_i+stop_i, ack_i=1, bit_rxd_i stream 0x3C -> READ×8, WR_ACK with bit_txd_o=1, STOP; dout_o=8'h3C.
REQ-025 write with bit_rxd_i=1 at ACK, no stop_i -> rxack_o=1; STOP issued only with I2C_BYTE_NACK_AUTOSTOP_EN.
REQ-026 arblost_i at 4th WRITE ack -> IDLE next cycle, arblost_o=1, busy_o=0, one done_o; next go_i clears arblost_o.
REQ-027 go_i while busy, then reset_n_i low mid-READ -> second go_i ignored; all outputs at reset values immediately.
